// File: rtl/tx_order_arbiter_if.sv
// ----------------------------------------------------------------------------
// tx_order_arbiter_if
// Bundles the order request bus and the shared order-output port of
// tx_order_arbiter.
//
// Signals:
//   req_addr     [NUM_REQ*8]  order address, requester i at [8i+7:8i]
//   req_buysell  [NUM_REQ*8]  buy/sell code, requester i at [8i+7:8i]
//   req_dv       [NUM_REQ]    one-cycle order strobe per requester
//   tx_ready                  downstream accepts the current output word
//   tx_addr      [8]          granted order address
//   tx_buysell   [8]          granted buy/sell code
//   tx_timestamp [32]         arrival timestamp of the granted order
//   tx_dv                     output word valid
//   ts_now       [32]         free-running timestamp counter
//   ovf          [NUM_REQ]    sticky per-requester overflow
//   drop_cnt     [NUM_REQ*16] per-requester drop counters
//                             (only when TX_ARB_DROP_CNT_EN is defined)
//
// Modports: master = requesters/downstream side, slave = the arbiter.
// ----------------------------------------------------------------------------
interface tx_order_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ*8-1:0]  req_addr;
    logic [NUM_REQ*8-1:0]  req_buysell;
    logic [NUM_REQ-1:0]    req_dv;
    logic                  tx_ready;
    logic [7:0]            tx_addr;
    logic [7:0]            tx_buysell;
    logic [31:0]           tx_timestamp;
    logic                  tx_dv;
    logic [31:0]           ts_now;
    logic [NUM_REQ-1:0]    ovf;
`ifdef TX_ARB_DROP_CNT_EN
    logic [NUM_REQ*16-1:0] drop_cnt;

    modport master (
        output req_addr, req_buysell, req_dv, tx_ready,
        input  tx_addr, tx_buysell, tx_timestamp, tx_dv, ts_now, ovf, drop_cnt
    );

    modport slave (
        input  req_addr, req_buysell, req_dv, tx_ready,
        output tx_addr, tx_buysell, tx_timestamp, tx_dv, ts_now, ovf, drop_cnt
    );
`else
    modport master (
        output req_addr, req_buysell, req_dv, tx_ready,
        input  tx_addr, tx_buysell, tx_timestamp, tx_dv, ts_now, ovf
    );

    modport slave (
        input  req_addr, req_buysell, req_dv, tx_ready,
        output tx_addr, tx_buysell, tx_timestamp, tx_dv, ts_now, ovf
    );
`endif
endinterface

// File: rtl/tx_order_arbiter.sv
// ----------------------------------------------------------------------------
// tx_order_arbiter
// Shares one order-output port among NUM_REQ decision modules. Every order is
// timestamped on arrival and queued in a per-requester FIFO; a round-robin
// scheduler drains the FIFOs into a single registered valid/ready stage.
//
// Parameters:
//   NUM_REQ    number of requesters (2..8)
//   FIFO_DEPTH entries per requester FIFO (power of 2, >= 2)
//
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      tx_order_arbiter_if.slave (request bus, output port, ts_now,
//            ovf, and drop_cnt when enabled)
//
// Optional feature: define TX_ARB_DROP_CNT_EN to add saturating 16-bit
// per-requester drop counters on bus.drop_cnt.
// ----------------------------------------------------------------------------
module tx_order_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    tx_order_arbiter_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LAST_W = $clog2(NUM_REQ);

    typedef enum logic {ST_EMPTY, ST_VALID} state_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  buysell;
        logic [31:0] ts;
    } entry_t;

    entry_t             mem_q    [NUM_REQ][FIFO_DEPTH];
    entry_t             mem_d    [NUM_REQ][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_REQ];
    logic [PTR_W-1:0]   wr_ptr_d [NUM_REQ];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_REQ];
    logic [PTR_W-1:0]   rd_ptr_d [NUM_REQ];
    logic [CNT_W-1:0]   count_q  [NUM_REQ];
    logic [CNT_W-1:0]   count_d  [NUM_REQ];

    logic [NUM_REQ-1:0] fifo_empty;
    logic [NUM_REQ-1:0] fifo_full;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] drop;
    logic [NUM_REQ-1:0] ovf_q, ovf_d;

    logic [31:0]        ts_q, ts_d;
    logic [LAST_W-1:0]  last_q, last_d;
    logic [LAST_W-1:0]  grant_idx;
    logic [LAST_W-1:0]  cand;
    logic               grant_valid;
    logic               load;
    entry_t             head;

    state_t             state_q, state_d;
    logic [7:0]         tx_addr_q, tx_addr_d;
    logic [7:0]         tx_buysell_q, tx_buysell_d;
    logic [31:0]        tx_ts_q, tx_ts_d;

    // Flags come from the registered counts, so a write is seen by the
    // scheduler one cycle later.
    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_empty[i] = (count_q[i] == '0);
            fifo_full[i]  = (count_q[i] == CNT_W'(FIFO_DEPTH));
        end
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = LAST_W'((int'(last_q) + k) % NUM_REQ);
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign head = mem_q[grant_idx][rd_ptr_q[grant_idx]];

    // A full FIFO that is popped this cycle still accepts its incoming order.
    always_comb begin
        load = (state_q == ST_EMPTY) || ((state_q == ST_VALID) && bus.tx_ready);
        pop  = '0;
        if (load && grant_valid) begin
            pop[grant_idx] = 1'b1;
        end
        push = bus.req_dv & (~fifo_full | pop);
        drop = bus.req_dv & fifo_full & ~pop;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = {bus.req_addr[8*i +: 8], bus.req_buysell[8*i +: 8], ts_q};
                wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            end
            if (push[i] && !pop[i]) begin
                count_d[i] = count_q[i] + 1'b1;
            end else if (!push[i] && pop[i]) begin
                count_d[i] = count_q[i] - 1'b1;
            end
        end
    end

    // Output stage: reload whenever empty or the held word is taken.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        tx_addr_d    = tx_addr_q;
        tx_buysell_d = tx_buysell_q;
        tx_ts_d      = tx_ts_q;
        if (load) begin
            if (grant_valid) begin
                state_d      = ST_VALID;
                last_d       = grant_idx;
                tx_addr_d    = head.addr;
                tx_buysell_d = head.buysell;
                tx_ts_d      = head.ts;
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_comb begin
        ts_d  = ts_q + 32'd1;
        ovf_d = ovf_q | drop;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            last_q       <= LAST_W'(NUM_REQ - 1);
            ts_q         <= '0;
            ovf_q        <= '0;
            tx_addr_q    <= '0;
            tx_buysell_q <= '0;
            tx_ts_q      <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            ts_q         <= ts_d;
            ovf_q        <= ovf_d;
            tx_addr_q    <= tx_addr_d;
            tx_buysell_q <= tx_buysell_d;
            tx_ts_q      <= tx_ts_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: flushing the counts and pointers empties it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef TX_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt_q [NUM_REQ];
    logic [15:0] drop_cnt_d [NUM_REQ];

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (drop[i] && (drop_cnt_q[i] != 16'hFFFF)) begin
                drop_cnt_d[i] = drop_cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                drop_cnt_q[i] <= '0;
            end
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        bus.drop_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.drop_cnt[16*i +: 16] = drop_cnt_q[i];
        end
    end
`endif

    assign bus.tx_addr      = tx_addr_q;
    assign bus.tx_buysell   = tx_buysell_q;
    assign bus.tx_timestamp = tx_ts_q;
    assign bus.tx_dv        = (state_q == ST_VALID);
    assign bus.ts_now       = ts_q;
    assign bus.ovf          = ovf_q;

endmodule

// File: doc/tx_order_arbiter.md
# tx_order_arbiter

Shares the single order-output port (`tx_addr`/`tx_buysell`/`tx_timestamp`/`tx_dv`) among the per-address decision-making modules. Each requester gets a small FIFO, and every order is timestamped when it arrives. A round-robin scheduler drains the FIFOs into one registered valid/ready output stage. The block sits between the per-address decision modules and the order transmit path in the system top.

## Interface
- `NUM_REQ`, default 4: number of requesters (decision modules); 2..8.
- `FIFO_DEPTH`, default 4: entries per requester FIFO; power of 2, ≥2.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `req_addr` in `NUM_REQ*8`: order address; requester i at [8i+7:8i].
- `req_buysell` in `NUM_REQ*8`: buy/sell code; requester i at [8i+7:8i].
- `req_dv` in `NUM_REQ`: one-cycle order strobe per requester.
- `tx_ready` in 1: downstream accepts the current output word.
- `tx_addr` out 8: granted order address.
- `tx_buysell` out 8: granted buy/sell code.
- `tx_timestamp` out 32: arrival timestamp of the granted order.
- `tx_dv` out 1: output word valid.
- `ts_now` out 32: free-running timestamp counter.
- `ovf` out `NUM_REQ`: sticky per-requester overflow (order dropped).

## Operation
- **Timestamp:**
  - `ts_now` is 0 in the first cycle after reset.
  - It increments by 1 every cycle and wraps 0xFFFFFFFF→0 with no flag.
- **Capture:**
  - `req_dv[i]`=1 in cycle N writes {addr, buysell, `ts_now`(N)} into FIFO i at the end of cycle N.
  - All requesters may write in the same cycle.
- **Overflow:**
  - FIFO i full and not popped in the same cycle: the incoming order is dropped and `ovf[i]` is set.
  - `ovf[i]` stays set until reset.
  - FIFO i full and popped in the same cycle: the write is accepted, with no overflow.
- **Output stage states:**
  - EMPTY: `tx_dv`=0.
  - VALID: `tx_dv`=1; `tx_addr`, `tx_buysell` and `tx_timestamp` are held stable.
- **Load condition:** `load = (state==EMPTY) | (tx_dv & tx_ready)`.
- **Transitions:**
  - On `load`: if any FIFO is non-empty, pop the granted FIFO, register its entry, go to (or stay in) VALID. Otherwise go to EMPTY.
  - VALID with `tx_ready`=0: hold everything.
- **Round-robin:**
  - The pointer `last` resets to `NUM_REQ-1`.
  - Search order is `last+1`, `last+2`, … mod `NUM_REQ`; the first non-empty FIFO wins.
  - `last` updates to the winner only when a pop occurs.
  - A requester that is continuously non-empty is served at least once every `NUM_REQ` grants.
- **Ordering:** per-requester FIFO order is preserved. Cross-requester order follows grant order, not timestamp.
- **Reset:**
  - Reset mid-operation flushes all FIFOs and the output stage (in-flight orders are lost).
  - Reset clears `ovf` and `ts_now` and sets `last=NUM_REQ-1`.
- **Reset values:** `tx_addr`, `tx_buysell`, `tx_timestamp`, `tx_dv`, `ts_now`, `ovf` are all 0.

## Timing
- **Latency:** with an idle output and empty FIFO, `req_dv` in cycle N gives `tx_dv`=1 in cycle N+2, with `tx_timestamp` = `ts_now` of cycle N.
- **Throughput:** 1 order/cycle while `tx_ready`=1 and any FIFO is non-empty. `tx_dv` stays high across back-to-back grants.
- **Backpressure:**
  - `tx_ready` is sampled only when `tx_dv`=1.
  - A word transfers in a cycle where `tx_dv` & `tx_ready`; the next word (if any) appears the following cycle.
- **FIFO flags:** full/empty are registered counts. A write in cycle N is visible to the arbiter in N+1.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.

## Configuration
- **Macro:** `TX_ARB_DROP_CNT_EN`.
- **With the macro defined:** adds output port `drop_cnt` (`NUM_REQ*16`; requester i at [16i+15:16i]).
  - Each drop increments the requester's counter, saturating at 0xFFFF.
  - Counters reset to 0.
  - `ovf[i]` behaves identically.
- **Without the macro:** the port and counters are absent; only the sticky `ovf` reports drops.

## Test plan
- **Single order:** after reset, `req_dv[0]`=1, addr 0x05, buysell 0x01 in cycle 10 (`ts_now`=10), `tx_ready`=1 → `tx_dv`=1 in cycle 12 with 0x05/0x01/`tx_timestamp`=10, then `tx_dv`=0.
- **Simultaneous requests:** all 4 `req_dv` pulse in one cycle with addr 0..3, `tx_ready`=1 → outputs addr 0,1,2,3 on 4 consecutive cycles with identical timestamps.
- **Backpressure:** `tx_ready`=0 for 5 cycles while `tx_dv`=1 → `tx_addr`/`tx_buysell`/`tx_timestamp` stay stable. Raising `tx_ready` → the next queued word appears the next cycle.
- **Overflow:** `tx_ready`=0 and 5 orders into requester 2 (`FIFO_DEPTH`=4, output stage already holding 1) → 1 order dropped and `ovf`=4'b0100. With `TX_ARB_DROP_CNT_EN`, `drop_cnt[2]`=1. After releasing `tx_ready`, exactly 5 orders emerge in order.
- **Fairness:** requesters 0 and 3 kept permanently non-empty → grants alternate 0,3,0,3.
- **Reset and wrap:** reset mid-stream → next cycle all outputs and `ovf` are 0, and no stale order is emitted. Forcing `ts_now` wrap (0xFFFFFFFF→0) → the next orders carry timestamps 0xFFFFFFFF then 0.
